qos_vc_arbiter: RTL

Parametrised successor to the fixed two-VC pop/mux/demux path between the virtual-channel FIFOs and the destination FIFOs. It supports NUM_VC virtual channels and NUM_DEST destinations, with runtime-selectable strict-priority or weighted-round-robin (WRR) arbitration. It issues VC pops, captures the popped word, decodes its destination field and writes it to one destination FIFO two cycles later. Occupancy backpressure comes from the destinations' almost-full flags.

---
 rtl/qos_pkg.sv | 31 +++
 rtl/wrr_arbiter.sv | 80 ++++++++
 rtl/qos_vc_arbiter.sv | 88 ++++++++
 3 files changed

// File: rtl/qos_pkg.sv
// Shared constants and helpers for the QoS virtual-channel arbiter.
// Mode encodings, default parameter values, cyclic next-set-bit search.
// Pure package: no timing or backpressure of its own.
package qos_pkg;

  localparam logic MODE_WRR    = 1'b0;
  localparam logic MODE_STRICT = 1'b1;

  localparam int DEF_BW       = 6;
  localparam int DEF_NUM_VC   = 2;
  localparam int DEF_NUM_DEST = 2;
  localparam int DEF_DEST_LSB = 4;
  localparam int DEF_WW       = 4;
  localparam int MAX_VC       = 8;

  // First set bit after 'from' in cyclic order over n entries, reaching
  // 'from' itself last. Returns {found, index}.
  function automatic logic [3:0] next_set(input logic [7:0] req,
                                          input logic [2:0] from,
                                          input int n);
    logic [3:0] res;
    res = '0;
    for (int i = MAX_VC; i >= 1; i--) begin
      if (i <= n) begin
        if (req[(int'(from) + i) % n]) res = {1'b1, 3'((int'(from) + i) % n)};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/wrr_arbiter.sv
// VC arbiter: strict priority (VC0 highest) or weighted round robin.
// Grant is combinational from req and registered cur/cred; zero latency.
// State advances only when the caller issues the pop (advance=1).
module wrr_arbiter
  import qos_pkg::*;
#(
  parameter int NUM_VC = DEF_NUM_VC,
  parameter int WW     = DEF_WW,
  parameter int VW     = $clog2(NUM_VC)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_VC-1:0]    req,
  input  logic [NUM_VC*WW-1:0] weight,
  input  logic                 mode,
  input  logic                 advance,
  output logic [NUM_VC-1:0]    grant,
  output logic [VW-1:0]        grant_idx
);

  logic [2:0]      cur;
  logic [WW-1:0]   cred;
  logic [7:0]      req8;
  logic [8*WW-1:0] w8;
  logic [3:0]      strict_sel, skip_sel, next_sel;
  logic [2:0]      wrr_idx, sel, cur_n;
  logic [WW-1:0]   w_sel, w_next, eff, rem, cred_n;
  logic            any_req;

  // Pad request and weight vectors to the search helper's fixed width
  always_comb begin
    req8 = '0;
    req8[NUM_VC-1:0] = req;
    w8 = '0;
    w8[NUM_VC*WW-1:0] = weight;
  end

  // Select the winner for each mode and precompute the WRR pointer/credit update
  always_comb begin
    strict_sel = next_set(req8, 3'(NUM_VC - 1), NUM_VC);
    skip_sel   = next_set(req8, cur, NUM_VC);
    // cur keeps the grant while it has requests; otherwise hop to the next requester
    wrr_idx    = req8[cur] ? cur : skip_sel[2:0];
    w_sel      = w8[int'(wrr_idx)*WW +: WW];
    if (w_sel == '0) w_sel = WW'(1);
    // cred == 0 only right after reset: the first grant reloads from the weight
    eff        = (req8[cur] && cred != '0) ? cred : w_sel;
    rem        = eff - WW'(1);
    next_sel   = next_set(req8, wrr_idx, NUM_VC);
    w_next     = w8[int'(next_sel[2:0])*WW +: WW];
    if (w_next == '0) w_next = WW'(1);
    cur_n  = wrr_idx;
    cred_n = rem;
    if (rem == '0 && next_sel[3]) begin
      cur_n  = next_sel[2:0];
      cred_n = w_next;
    end
    if (mode == MODE_STRICT) begin
      sel     = strict_sel[2:0];
      any_req = strict_sel[3];
    end else begin
      sel     = wrr_idx;
      any_req = skip_sel[3];
    end
    for (int k = 0; k < NUM_VC; k++) grant[k] = any_req && (int'(sel) == k);
    grant_idx = VW'(sel);
  end

  // WRR state moves only on an issued WRR grant; strict mode leaves it frozen
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur  <= '0;
      cred <= '0;
    end else if (advance && mode == MODE_WRR && skip_sel[3]) begin
      cur  <= cur_n;
      cred <= cred_n;
    end
  end

endmodule

// File: rtl/qos_vc_arbiter.sv
// Pops VC FIFOs by strict/WRR arbitration and routes each word to its destination FIFO.
// Pop-to-push latency 2 cycles; one word per cycle sustained.
// Pops stall while any destination is almost full; up to 2 words stay in flight.
module qos_vc_arbiter
  import qos_pkg::*;
#(
  parameter int BW       = DEF_BW,
  parameter int NUM_VC   = DEF_NUM_VC,
  parameter int NUM_DEST = DEF_NUM_DEST,
  parameter int DEST_LSB = DEF_DEST_LSB,
  parameter int WW       = DEF_WW
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         mode,
  input  logic [NUM_VC*WW-1:0]         vc_weight,
  input  logic [NUM_VC-1:0]            vc_empty,
  input  logic [NUM_VC*BW-1:0]         vc_data_out,
  output logic [NUM_VC-1:0]            vc_rd,
  input  logic [NUM_DEST-1:0]          dest_almost_full,
  input  logic [NUM_DEST-1:0]          dest_full,
  output logic [NUM_DEST-1:0]          dest_wr,
  output logic [BW-1:0]                dest_data_in,
  output logic [$clog2(NUM_VC)-1:0]    grant_vc,
  output logic                         drop_err
);

  localparam int DW = $clog2(NUM_DEST);
  localparam int VW = $clog2(NUM_VC);

  logic              issue;
  logic [NUM_VC-1:0] arb_grant;
  logic [VW-1:0]     arb_idx, last_grant, p1_idx;
  logic              p1_vld, cap_vld, wr_ok;
  logic [BW-1:0]     cap_dat;
  logic [DW-1:0]     dsel;

  wrr_arbiter #(.NUM_VC(NUM_VC), .WW(WW), .VW(VW)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (~vc_empty),
    .weight    (vc_weight),
    .mode      (mode),
    .advance   (issue),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  // Pop only with room in every destination: the target is unknown until the word is read
  always_comb begin
    issue    = (|(~vc_empty)) && !(|dest_almost_full) && !reset;
    vc_rd    = issue ? arb_grant : '0;
    grant_vc = issue ? arb_idx : last_grant;
  end

  // Track the pop, capture read data the following cycle, and latch any drop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p1_vld     <= 1'b0;
      p1_idx     <= '0;
      last_grant <= '0;
      cap_vld    <= 1'b0;
      cap_dat    <= '0;
      drop_err   <= 1'b0;
    end else begin
      p1_vld  <= issue;
      cap_vld <= p1_vld;
      if (issue) begin
        p1_idx     <= arb_idx;
        last_grant <= arb_idx;
      end
      if (p1_vld) cap_dat <= vc_data_out[int'(p1_idx)*BW +: BW];
      if (cap_vld && !wr_ok) drop_err <= 1'b1;
    end
  end

  // Decode the captured word's destination; out-of-range or full targets are dropped
  always_comb begin
    dsel  = cap_dat[DEST_LSB +: DW];
    wr_ok = 1'b0;
    for (int k = 0; k < NUM_DEST; k++) begin
      if (int'(dsel) == k) wr_ok = cap_vld && !dest_full[k];
    end
    for (int k = 0; k < NUM_DEST; k++) dest_wr[k] = wr_ok && (int'(dsel) == k);
    dest_data_in = cap_dat;
  end

endmodule
